usb_rx_controller: RTL
======================

# usb_rx_controller

Receive-side packet controller for the USB full-speed endpoint, the counterpart of the transmit controller. It sits between the bit-level receive front end (NRZI decoder, edge and EOP detectors, bit-unstuffing timer, 8-bit shift register, CRC16 checker) and the receive FIFO. It validates SYNC and PID, and strips the trailing two CRC bytes through a 2-byte holding pipe so that only payload reaches the FIFO. It reports packet completion and errors to the protocol layer.

## Interface
Parameters:
- MAX_BYTES, 66 — maximum bytes after the PID (payload plus 2 CRC bytes); exceeding it is an overflow error.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- d_edge  in  1  first line transition after idle; starts a packet
- eop  in  1  SE0 currently detected
- shift_enable  in  1  one-cycle strobe per received (unstuffed) bit
- byte_received  in  1  one-cycle strobe; rcv_data holds a complete byte this cycle
- rcv_data  in  8  assembled byte, LSB first on the wire
- crc_match  in  1  CRC16 residual correct; valid while eop is high
- rcving  out  1  packet reception in progress
- w_enable  out  1  one-cycle FIFO write strobe
- rx_data  out  8  byte to FIFO, valid with w_enable
- rx_pid  out  4  PID of the current/last packet
- byte_count  out  7  payload bytes written for the current packet
- crc_clear  out  1  one-cycle clear for the CRC16 checker
- rx_packet_done  out  1  one-cycle pulse, packet accepted
- r_error  out  1  sticky error flag

## Operation
- Reset: all outputs 0; state IDLE; holding pipe empty; bit counter 0.
- IDLE: d_edge → RCV_SYNC; rcving=1; r_error cleared; byte_count cleared.
- RCV_SYNC: on byte_received, rcv_data==8'h80 → RCV_PID, otherwise → ERR.
- RCV_PID: on byte_received, require rcv_data[7:4]==~rcv_data[3:0].
  - DATA0 (4'b0011) or DATA1 (4'b1011): load rx_pid, pulse crc_clear, → RCV_DATA.
  - ACK (4'b0010), NAK (4'b1010), STALL (4'b1110): load rx_pid, → WAIT_EOP_HS.
  - Any other PID, or a complement failure: → ERR.
- WAIT_EOP_HS: eop&&shift_enable → EOP_WAIT. byte_received → ERR.
- RCV_DATA, on byte_received:
  - Push rcv_data into the 2-deep pipe.
  - If the pipe was already full, pop the oldest entry to rx_data, pulse w_enable and increment byte_count.
  - A push that makes the bytes-after-PID count exceed MAX_BYTES → ERR.
- Bit counter: 3-bit, counts shift_enable in RCV_DATA, zeroed by byte_received.
- EOP in RCV_DATA (eop&&shift_enable):
  - bit counter==0 and pipe full → EOP_WAIT.
  - Otherwise (mid-byte, or fewer than 2 bytes after PID) → ERR.
- EOP_WAIT: hold until eop==0, then:
  - Data packet: crc_match sampled on the last cycle eop==1; 1 → DONE, 0 → ERR.
  - Handshake packet → DONE.
- DONE: rx_packet_done=1 for one cycle; pipe flushed without writing (the two CRC bytes are discarded); rcving=0 → IDLE.
- ERR: r_error=1; rcving stays 1 until eop has been seen high then low, then → IDLE with r_error held. Nothing further is written.
- An eop in RCV_SYNC or RCV_PID → ERR.
- Simultaneous byte_received and eop&&shift_enable: the byte is processed first, then the EOP check uses the updated counters.

## Timing
- All outputs are registered.
- byte_received at cycle t with the pipe full → w_enable and rx_data at t+1.
- crc_clear is asserted at t+1 after the accepted PID byte at t.
- DONE is entered the cycle after eop falls; rx_packet_done follows 1 cycle later (Moore).
- r_error rises 1 cycle after the offending event and stays high until the next d_edge in IDLE.
- n_rst low mid-packet: immediate return to reset values; the partial packet is not signalled.

## Structure
- Shared package usb_pkg holds:
  - PID constants;
  - SYNC_BYTE=8'h80;
  - the rx state enum (IDLE, RCV_SYNC, RCV_PID, WAIT_EOP_HS, RCV_DATA, EOP_WAIT, DONE, ERR);
  - MAX_BYTES default.
- One sub-module, usb_rx_byte_pipe: a 2-entry shift pipe with push, flush, full and the popped byte.

## Test plan
- SYNC 80, PID C3 (DATA0), bytes 11 22 33, CRC bytes, crc_match=1, EOP → w_enable ×3 with 11,22,33; byte_count=3; rx_packet_done pulse; r_error=0.
- SYNC 80, PID D2 (ACK), EOP → rx_pid=2, no w_enable, rx_packet_done pulse.
- SYNC 81 → r_error=1, no w_enable; after EOP, next d_edge clears r_error.
- DATA1 4B with bytes AA BB, CRC, crc_match=0 → 2 writes, then r_error=1, no rx_packet_done.
- EOP after 3 bits of a data byte → r_error=1; 67 bytes after PID with MAX_BYTES=66 → r_error=1 on the 67th byte.
- n_rst asserted mid-payload → all outputs 0 next edge; a clean following packet is received correctly.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB full-speed constants and the receive controller state encoding.
package usb_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam int unsigned MAX_BYTES_DEFAULT = 66;

  typedef enum logic [2:0] {
    StIdle,
    StRcvSync,
    StRcvPid,
    StWaitEopHs,
    StRcvData,
    StEopWait,
    StDone,
    StErr
  } rx_state_e;

  // Upper nibble of a PID byte is the one's complement of the lower nibble.
  function automatic logic pid_check_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/usb_rx_byte_pipe.sv
// Two-entry byte delay line; the two newest bytes of a packet (its CRC) never leave it.
module usb_rx_byte_pipe (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       flush_i,
  output logic       full_o,
  output logic [1:0] level_o,
  output logic [7:0] pop_data_o
);

  logic [7:0] slot0_q, slot0_d;
  logic [7:0] slot1_q, slot1_d;
  logic [1:0] level_q, level_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    level_d = level_q;
    if (flush_i) begin
      level_d = 2'd0;
    end else if (push_i) begin
      unique case (level_q)
        2'd0: begin
          slot0_d = data_i;
          level_d = 2'd1;
        end
        2'd1: begin
          slot1_d = data_i;
          level_d = 2'd2;
        end
        default: begin
          slot0_d = slot1_q;
          slot1_d = data_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot0_q <= 8'h00;
      slot1_q <= 8'h00;
      level_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      level_q <= level_d;
    end
  end

  assign full_o     = (level_q == 2'd2);
  assign level_o    = level_q;
  assign pop_data_o = slot0_q;

endmodule

// File: rtl/usb_rx_controller.sv
// USB full-speed receive packet controller: SYNC/PID checks, CRC stripping, FIFO writes.
module usb_rx_controller
  import usb_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       crc_match,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] rx_data,
  output logic [3:0] rx_pid,
  output logic [6:0] byte_count,
  output logic       crc_clear,
  output logic       rx_packet_done,
  output logic       r_error
);

  localparam int unsigned CntW = $clog2(MAX_BYTES + 2);

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] pid_cnt_q, pid_cnt_d;
  logic            is_data_q, is_data_d;
  logic            crc_ok_q, crc_ok_d;
  logic            eop_seen_q, eop_seen_d;
  logic            rcving_q, rcving_d;
  logic            w_enable_q, w_enable_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [3:0]      rx_pid_q, rx_pid_d;
  logic [6:0]      byte_count_q, byte_count_d;
  logic            crc_clear_q, crc_clear_d;
  logic            done_q, done_d;
  logic            r_error_q, r_error_d;

  logic       pipe_push, pipe_flush, pipe_full;
  logic [1:0] pipe_level;
  logic [7:0] pipe_pop;
  logic       eop_bit, full_after;
  logic [2:0] bit_cnt_chk;

  usb_rx_byte_pipe u_pipe (
    .clk_i      (clk),
    .rst_ni     (n_rst),
    .push_i     (pipe_push),
    .data_i     (rcv_data),
    .flush_i    (pipe_flush),
    .full_o     (pipe_full),
    .level_o    (pipe_level),
    .pop_data_o (pipe_pop)
  );

  assign eop_bit = eop & shift_enable;
  // A byte arriving with the EOP is consumed first, so the EOP sees post-byte counters.
  assign bit_cnt_chk = byte_received ? 3'd0 : bit_cnt_q;
  assign full_after  = byte_received ? (pipe_level != 2'd0) : pipe_full;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    pid_cnt_d    = pid_cnt_q;
    is_data_d    = is_data_q;
    crc_ok_d     = crc_ok_q;
    eop_seen_d   = eop_seen_q;
    rcving_d     = rcving_q;
    w_enable_d   = 1'b0;
    rx_data_d    = rx_data_q;
    rx_pid_d     = rx_pid_q;
    byte_count_d = byte_count_q;
    crc_clear_d  = 1'b0;
    done_d       = 1'b0;
    r_error_d    = r_error_q;
    pipe_push    = 1'b0;
    pipe_flush   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_edge) begin
          state_d      = StRcvSync;
          rcving_d     = 1'b1;
          r_error_d    = 1'b0;
          byte_count_d = 7'd0;
          bit_cnt_d    = 3'd0;
          pid_cnt_d    = '0;
          eop_seen_d   = 1'b0;
          crc_ok_d     = 1'b0;
          pipe_flush   = 1'b1;
        end
      end
      StRcvSync: begin
        if (eop || (byte_received && rcv_data != SYNC_BYTE)) begin
          state_d    = StErr;
          r_error_d  = 1'b1;
          eop_seen_d = eop;
        end else if (byte_received) begin
          state_d = StRcvPid;
        end
      end
      StRcvPid: begin
        if (eop) begin
          state_d    = StErr;
          r_error_d  = 1'b1;
          eop_seen_d = 1'b1;
        end else if (byte_received) begin
          state_d    = StErr;
          r_error_d  = 1'b1;
          eop_seen_d = 1'b0;
          if (pid_check_ok(rcv_data)) begin
            if (rcv_data[3:0] == PID_DATA0 || rcv_data[3:0] == PID_DATA1) begin
              state_d     = StRcvData;
              r_error_d   = r_error_q;
              rx_pid_d    = rcv_data[3:0];
              is_data_d   = 1'b1;
              crc_clear_d = 1'b1;
            end else if (rcv_data[3:0] == PID_ACK || rcv_data[3:0] == PID_NAK ||
                         rcv_data[3:0] == PID_STALL) begin
              state_d   = StWaitEopHs;
              r_error_d = r_error_q;
              rx_pid_d  = rcv_data[3:0];
              is_data_d = 1'b0;
            end
          end
        end
      end
      StWaitEopHs: begin
        if (byte_received) begin
          state_d    = StErr;
          r_error_d  = 1'b1;
          eop_seen_d = eop;
        end else if (eop_bit) begin
          state_d = StEopWait;
        end
      end
      StRcvData: begin
        if (byte_received) begin
          bit_cnt_d = 3'd0;
          pid_cnt_d = pid_cnt_q + CntW'(1);
          if (32'(pid_cnt_q) + 32'd1 > MAX_BYTES) begin
            state_d    = StErr;
            r_error_d  = 1'b1;
            eop_seen_d = eop;
          end else begin
            pipe_push = 1'b1;
            if (pipe_full) begin
              w_enable_d   = 1'b1;
              rx_data_d    = pipe_pop;
              byte_count_d = byte_count_q + 7'd1;
            end
          end
        end else if (shift_enable) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (eop_bit && state_d == StRcvData) begin
          if (bit_cnt_chk == 3'd0 && full_after) begin
            state_d  = StEopWait;
            crc_ok_d = crc_match;
          end else begin
            state_d    = StErr;
            r_error_d  = 1'b1;
            eop_seen_d = 1'b1;
          end
        end
      end
      StEopWait: begin
        if (eop) begin
          crc_ok_d = crc_match;
        end else if (!is_data_q || crc_ok_q) begin
          state_d = StDone;
        end else begin
          state_d    = StErr;
          r_error_d  = 1'b1;
          eop_seen_d = 1'b1;
        end
      end
      StDone: begin
        done_d     = 1'b1;
        pipe_flush = 1'b1;
        rcving_d   = 1'b0;
        state_d    = StIdle;
      end
      StErr: begin
        if (eop) begin
          eop_seen_d = 1'b1;
        end else if (eop_seen_q) begin
          rcving_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      pid_cnt_q    <= '0;
      is_data_q    <= 1'b0;
      crc_ok_q     <= 1'b0;
      eop_seen_q   <= 1'b0;
      rcving_q     <= 1'b0;
      w_enable_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_pid_q     <= 4'h0;
      byte_count_q <= 7'd0;
      crc_clear_q  <= 1'b0;
      done_q       <= 1'b0;
      r_error_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      pid_cnt_q    <= pid_cnt_d;
      is_data_q    <= is_data_d;
      crc_ok_q     <= crc_ok_d;
      eop_seen_q   <= eop_seen_d;
      rcving_q     <= rcving_d;
      w_enable_q   <= w_enable_d;
      rx_data_q    <= rx_data_d;
      rx_pid_q     <= rx_pid_d;
      byte_count_q <= byte_count_d;
      crc_clear_q  <= crc_clear_d;
      done_q       <= done_d;
      r_error_q    <= r_error_d;
    end
  end

  assign rcving         = rcving_q;
  assign w_enable       = w_enable_q;
  assign rx_data        = rx_data_q;
  assign rx_pid         = rx_pid_q;
  assign byte_count     = byte_count_q;
  assign crc_clear      = crc_clear_q;
  assign rx_packet_done = done_q;
  assign r_error        = r_error_q;

endmodule
